// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state encoding and the add-3 digit adjust constants.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int BCD_DIGIT_W    = 4;
    localparam int BCD_ADJ_THRESH = 5;
    localparam int BCD_ADJ_ADD    = 3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational double-dabble digit cell: add 3 (mod 16) when digit >= 5.
// One instance per BCD digit of the accumulator.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d_i,
    output logic [BCD_DIGIT_W-1:0] d_o
);

    // Pre-shift correction so the following doubling carries in decimal
    always_comb begin
        d_o = d_i;
        if (d_i >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) begin
            d_o = d_i + BCD_DIGIT_W'(BCD_ADJ_ADD);
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock (double dabble).
// Optional two's-complement input with sign output: BIN2BCD_SIGNED_EN.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int W      = 14,
    parameter int DIGITS = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [W-1:0]                  in_bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
    output logic                          out_ovf,
    output logic                          out_neg
);

    localparam int BW = BCD_DIGIT_W * DIGITS;
    localparam int CW = $clog2(W);

    state_e         state_q, state_d;
    logic [W-1:0]   sr_q, sr_d;
    logic [BW-1:0]  acc_q, acc_d;
    logic [BW-1:0]  adj;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ovf_q, ovf_d;
    logic [W-1:0]   load_val;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .d_o (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

`ifdef BIN2BCD_SIGNED_EN
    logic neg_q, neg_d;

    // Magnitude of the operand; -2^(W-1) maps to 2^(W-1) as unsigned
    always_comb begin
        load_val = in_bin;
        if (in_bin[W-1]) begin
            load_val = (~in_bin) + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Sign flag, captured on accept
    always_comb begin
        neg_d = neg_q;
        if (state_q == ST_IDLE && in_valid) begin
            neg_d = in_bin[W-1];
        end
    end

    // Sign register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end

    assign out_neg = neg_q;
`else
    assign load_val = in_bin;
    assign out_neg  = 1'b0;
`endif

    // Next state and datapath: load on accept, adjust-then-shift per bit
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sr_d    = load_val;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CW'(W - 1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc_d = {adj[BW-2:0], sr_q[W-1]};
                sr_d  = {sr_q[W-2:0], 1'b0};
                ovf_d = ovf_q | adj[BW-1];
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_bcd   = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench: default 5-digit converter plus a 4-digit one on shared inputs.
// Table of conversions, then stall, throughput and mid-conversion reset sequences.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [13:0] in_bin;
    logic        out_ready;

    logic        ready5, valid5, ovf5, neg5;
    logic [19:0] bcd5;
    logic        ready4, valid4, ovf4, neg4;
    logic [15:0] bcd4;

    int total;
    int bad;

    bin2bcd_seq #(.W(14), .DIGITS(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (ready5),
        .in_bin    (in_bin),
        .out_valid (valid5),
        .out_ready (out_ready),
        .out_bcd   (bcd5),
        .out_ovf   (ovf5),
        .out_neg   (neg5)
    );

    bin2bcd_seq #(.W(14), .DIGITS(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (ready4),
        .in_bin    (in_bin),
        .out_valid (valid4),
        .out_ready (out_ready),
        .out_bcd   (bcd4),
        .out_ovf   (ovf4),
        .out_neg   (neg4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] bin;
        logic [19:0] bcd;
        logic        neg;
        logic        ovf4;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic start(input logic [13:0] b);
        int n;
        n = 0;
        while (!ready5 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        in_bin   = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!valid5 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [19:0] held;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bin    = '0;
        out_ready = 1'b0;

`ifdef BIN2BCD_SIGNED_EN
        vecs[0] = '{14'd0,     20'h00000, 1'b0, 1'b0};
        vecs[1] = '{14'd1234,  20'h01234, 1'b0, 1'b0};
        vecs[2] = '{14'd8191,  20'h08191, 1'b0, 1'b0};
        vecs[3] = '{14'h3fff,  20'h00001, 1'b1, 1'b0};
        vecs[4] = '{14'h2000,  20'h08192, 1'b1, 1'b0};
        vecs[5] = '{14'd15150, 20'h01234, 1'b1, 1'b0};
        vecs[6] = '{14'd1,     20'h00001, 1'b0, 1'b0};
        vecs[7] = '{14'd4096,  20'h04096, 1'b0, 1'b0};
`else
        vecs[0] = '{14'd9999,  20'h09999, 1'b0, 1'b0};
        vecs[1] = '{14'd0,     20'h00000, 1'b0, 1'b0};
        vecs[2] = '{14'd16383, 20'h16383, 1'b0, 1'b1};
        vecs[3] = '{14'd1234,  20'h01234, 1'b0, 1'b0};
        vecs[4] = '{14'd10000, 20'h10000, 1'b0, 1'b1};
        vecs[5] = '{14'd1,     20'h00001, 1'b0, 1'b0};
        vecs[6] = '{14'd8192,  20'h08192, 1'b0, 1'b0};
        vecs[7] = '{14'd4096,  20'h04096, 1'b0, 1'b0};
`endif

        #12;
        check("reset_state", {ready5, valid5, bcd5, ovf5, neg5},
              {1'b1, 1'b0, 20'h0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            start(vecs[i].bin);
            wait_done(lat);
            check($sformatf("latency[%0d]", i), lat, 14);
            check($sformatf("bcd[%0d]", i), bcd5, vecs[i].bcd);
            check($sformatf("ovf[%0d]", i), ovf5, 1'b0);
            check($sformatf("neg[%0d]", i), neg5, vecs[i].neg);
            check($sformatf("valid4[%0d]", i), valid4, 1'b1);
            check($sformatf("ovf4[%0d]", i), ovf4, vecs[i].ovf4);
            if (!vecs[i].ovf4) begin
                check($sformatf("bcd4[%0d]", i), bcd4, vecs[i].bcd[15:0]);
            end
            handshake();
            check($sformatf("idle_after[%0d]", i), ready5, 1'b1);
        end

        start(14'd4321);
        wait_done(lat);
        check("stall_latency", lat, 14);
        held = bcd5;
        check("stall_value", held, 20'h04321);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_bin   = (i == 19) ? 14'd1234 : 14'(i * 7 + 100);
            @(posedge clk);
            #1;
            check($sformatf("stall[%0d]", i), {ready5, valid5, bcd5},
                  {1'b0, 1'b1, held});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_idle", {ready5, valid5}, {1'b1, 1'b0});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("accept_after_release", ready5, 1'b0);
        wait_done(lat);
        check("late_accept_latency", lat, 14);
        check("late_accept_bcd", bcd5, 20'h01234);
        handshake();

        in_bin    = 14'd4321;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i <= 48; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("tput_ready[%0d]", i), ready5, (i % 16) == 0);
            if (valid5) begin
                check($sformatf("tput_bcd[%0d]", i), bcd5, 20'h04321);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;

        start(14'd12345);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midshift_reset", {ready5, valid5, bcd5, ovf5, neg5, ovf4},
              {1'b1, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        rst = 1'b0;
        start(14'd1234);
        wait_done(lat);
        check("post_reset_latency", lat, 14);
        check("post_reset_bcd", bcd5, 20'h01234);
        check("post_reset_neg", neg5, 1'b0);
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
